// File: rtl/id_ex_stage_reg.sv
//==============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with load-use hazard bubble insertion,
//               branch flush, backpressure hold and a saturating stall counter.
//               Optional macro STORE_FWD_BYPASS_EN: a store whose data operand
//               (rs2) is the only dependency on an in-flight load does not stall.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    input  logic              ex_ready,
    output logic              ID_EX_Valid,
    output logic [XLEN-1:0]   ID_EX_PC,
    output logic [XLEN-1:0]   ID_EX_Rs1_Data,
    output logic [XLEN-1:0]   ID_EX_Rs2_Data,
    output logic [XLEN-1:0]   ID_EX_Imm,
    output logic [REG_AW-1:0] ID_EX_Rs1,
    output logic [REG_AW-1:0] ID_EX_Rs2,
    output logic [REG_AW-1:0] ID_EX_Rd,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int C_MEMREAD_BIT = CTRL_W - 2;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic w_hz_base;
    logic w_store_rs2_only;
    logic w_hz;
    logic w_hz_run;

    assign w_hz_base = valid_q & ctrl_q[C_MEMREAD_BIT] & (rd_q != '0) & id_valid &
                       ((rd_q == id_rs1) | (id_uses_rs2 & (rd_q == id_rs2)));

`ifdef STORE_FWD_BYPASS_EN
    localparam int C_MEMWRITE_BIT = CTRL_W - 3;
    // Store data can be picked up by the MEM-stage WB->MEM forward, so only
    // an address (rs1) dependency has to stall.
    assign w_store_rs2_only = id_ctrl[C_MEMWRITE_BIT] & (rd_q == id_rs2) & (rd_q != id_rs1);
`else
    assign w_store_rs2_only = 1'b0;
`endif

    assign w_hz     = w_hz_base & ~w_store_rs2_only;
    assign w_hz_run = w_hz & (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;

        if (ex_flush) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            ctrl_d     = '0;
            state_d    = ST_RUN;
        end else if (!ex_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (w_hz_run) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            ctrl_d      = '0;
            state_d     = ST_BUBBLE;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            ctrl_d     = id_valid ? id_ctrl : '0;
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ID_EX_Valid    = valid_q;
    assign ID_EX_PC       = pc_q;
    assign ID_EX_Rs1_Data = rs1_data_q;
    assign ID_EX_Rs2_Data = rs2_data_q;
    assign ID_EX_Imm      = imm_q;
    assign ID_EX_Rs1      = rs1_q;
    assign ID_EX_Rs2      = rs2_q;
    assign ID_EX_Rd       = rd_q;
    assign ID_EX_Ctrl     = ctrl_q;
    assign stall_cnt      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
//==============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Self-checking bench for id_ex_stage_reg (honours
//               STORE_FWD_BYPASS_EN when defined for the build).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_stage_reg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 10;
    // Narrow counter so saturation is reachable in a short run.
    localparam int CNT_W  = 8;

    localparam logic [CTRL_W-1:0] C_LW  = 10'h360;
    localparam logic [CTRL_W-1:0] C_ADD = 10'h200;
    localparam logic [CTRL_W-1:0] C_SW  = 10'h0A0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_uses_rs2;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_flush, ex_ready;
    logic              ID_EX_Valid;
    logic [XLEN-1:0]   ID_EX_PC, ID_EX_Rs1_Data, ID_EX_Rs2_Data, ID_EX_Imm;
    logic [REG_AW-1:0] ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
    logic [CTRL_W-1:0] ID_EX_Ctrl;
    logic              pc_write, if_id_write;
    logic [CNT_W-1:0]  stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference view of the EX slot
    logic              m_valid;
    logic [XLEN-1:0]   m_pc, m_d1, m_d2, m_imm;
    logic [REG_AW-1:0] m_rs1, m_rs2, m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_cnt;

    id_ex_stage_reg #(
        .XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ex_ready(ex_ready),
        .ID_EX_Valid(ID_EX_Valid), .ID_EX_PC(ID_EX_PC),
        .ID_EX_Rs1_Data(ID_EX_Rs1_Data), .ID_EX_Rs2_Data(ID_EX_Rs2_Data),
        .ID_EX_Imm(ID_EX_Imm),
        .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_Ctrl(ID_EX_Ctrl),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_cnt = 0;
    endtask

    // Load-use: the instruction in EX is a load whose destination ID reads.
    function automatic logic model_hz();
        logic dep_rs1, dep_rs2;
        if (!(m_valid && m_ctrl[8] && m_rd != 0 && id_valid)) return 1'b0;
        dep_rs1 = (m_rd == id_rs1);
        dep_rs2 = id_uses_rs2 && (m_rd == id_rs2);
`ifdef STORE_FWD_BYPASS_EN
        if (id_ctrl[7] && !dep_rs1) return 1'b0;
`endif
        return dep_rs1 || dep_rs2;
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ".valid"}, 64'(ID_EX_Valid),    64'(m_valid));
        check({ctx, ".pc"},    64'(ID_EX_PC),       64'(m_pc));
        check({ctx, ".d1"},    64'(ID_EX_Rs1_Data), 64'(m_d1));
        check({ctx, ".d2"},    64'(ID_EX_Rs2_Data), 64'(m_d2));
        check({ctx, ".imm"},   64'(ID_EX_Imm),      64'(m_imm));
        check({ctx, ".rs1"},   64'(ID_EX_Rs1),      64'(m_rs1));
        check({ctx, ".rs2"},   64'(ID_EX_Rs2),      64'(m_rs2));
        check({ctx, ".rd"},    64'(ID_EX_Rd),       64'(m_rd));
        check({ctx, ".ctrl"},  64'(ID_EX_Ctrl),     64'(m_ctrl));
        check({ctx, ".cnt"},   64'(stall_cnt),      64'(m_cnt));
    endtask

    // Inputs are set right after a falling edge; one call covers one clock.
    task automatic cycle(input string ctx);
        logic hz, exp_w;
        #1;
        hz    = model_hz();
        exp_w = ex_flush || (ex_ready && !hz);
        check({ctx, ".pc_write"},    64'(pc_write),    64'(exp_w));
        check({ctx, ".if_id_write"}, 64'(if_id_write), 64'(exp_w));
        @(posedge clk);
        if (ex_flush || (ex_ready && hz)) begin
            m_valid = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
            if (!ex_flush && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (ex_ready) begin
            m_valid = id_valid; m_pc = id_pc; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
            m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_ctrl = id_valid ? id_ctrl : '0;
        end
        #1;
        check_all(ctx);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input int rs1, input int rs2, input int rd,
                          input logic u2, input logic [CTRL_W-1:0] ctrl);
        id_valid    = v;
        id_pc       = $urandom;
        id_rs1      = REG_AW'(rs1);
        id_rs2      = REG_AW'(rs2);
        id_rd       = REG_AW'(rd);
        id_uses_rs2 = u2;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_ctrl     = ctrl;
    endtask

    initial begin
        logic [REG_AW-1:0] held_rs1;
        int                cnt_before;
        rst_n = 1'b0; ex_flush = 1'b0; ex_ready = 1'b1;
        set_id(1'b0, 0, 0, 0, 1'b0, '0);
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // lw x5,0(x1) ; add x6,x5,x2 -> one bubble
        set_id(1'b1, 1, 0, 5, 1'b0, C_LW);   cycle("lu_lw");
        set_id(1'b1, 5, 2, 6, 1'b1, C_ADD);  cycle("lu_bub");
        check("lu_bub_valid", 64'(ID_EX_Valid), 64'd0);
        cycle("lu_add");
        check("lu_add_rs1", 64'(ID_EX_Rs1), 64'd5);
        check("lu_cnt",     64'(stall_cnt), 64'd1);

        // rd=x0 and unrelated registers never stall
        set_id(1'b1, 1, 0, 0, 1'b0, C_LW);   cycle("x0_lw");
        set_id(1'b1, 0, 2, 6, 1'b1, C_ADD);  cycle("x0_add");
        set_id(1'b1, 1, 0, 5, 1'b0, C_LW);   cycle("nd_lw");
        set_id(1'b1, 7, 8, 6, 1'b1, C_ADD);  cycle("nd_add");
        check("nd_cnt", 64'(stall_cnt), 64'd1);

        // Store data dependency (bypassable) and address dependency
        set_id(1'b1, 1, 0, 5, 1'b0, C_LW);   cycle("sd_lw");
        set_id(1'b1, 1, 5, 0, 1'b1, C_SW);   cycle("sd_sw0");
        cycle("sd_sw1");
        set_id(1'b1, 1, 0, 5, 1'b0, C_LW);   cycle("sa_lw");
        set_id(1'b1, 5, 7, 0, 1'b1, C_SW);   cycle("sa_bub");
        check("sa_bub_valid", 64'(ID_EX_Valid), 64'd0);
        cycle("sa_sw");

        // Flush during a hazard wins; counter untouched
        set_id(1'b1, 1, 0, 5, 1'b0, C_LW);   cycle("fl_lw");
        cnt_before = m_cnt;
        set_id(1'b1, 5, 2, 6, 1'b1, C_ADD);  ex_flush = 1'b1; cycle("fl_hz");
        ex_flush = 1'b0;
        check("fl_cnt", 64'(stall_cnt), 64'(cnt_before));

        // Backpressure: hold three cycles, load on release
        set_id(1'b1, 3, 4, 9, 1'b1, C_ADD);  cycle("bp_pre");
        held_rs1 = ID_EX_Rs1;
        set_id(1'b1, 11, 12, 13, 1'b1, C_ADD);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("bp_hold");
        check("bp_held_rs1", 64'(ID_EX_Rs1), 64'(held_rs1));
        ex_ready = 1'b1;                     cycle("bp_go");
        check("bp_go_rs1", 64'(ID_EX_Rs1), 64'd11);

        // Asynchronous reset while sitting in the bubble
        set_id(1'b1, 1, 0, 5, 1'b0, C_LW);   cycle("rb_lw");
        set_id(1'b1, 5, 2, 6, 1'b1, C_ADD);  cycle("rb_bub");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("rb_rst");
        @(negedge clk); rst_n = 1'b1;
        cycle("rb_run0");
        cycle("rb_run1");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 6) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom), CTRL_W'($urandom));
            ex_flush = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 4) != 0);
            cycle("rnd");
        end
        ex_flush = 1'b0; ex_ready = 1'b1;

        // Back-to-back dependent loads drive the counter into saturation
        set_id(1'b1, 5, 0, 5, 1'b0, C_LW);
        for (int i = 0; i < 2 * ((1 << CNT_W) + 5) + 2; i++) cycle("sat");
        check("sat_final", 64'(stall_cnt), 64'((1 << CNT_W) - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
